// File: rtl/mac_pkg.sv
// Shared types and constants for the receive MAC frame checker.
package mac_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned CNT_W         = 10;
    localparam int unsigned LEN_W         = 11;
    localparam int unsigned BYTE_W        = 12;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    localparam int unsigned ETH_MIN_BYTES = 64;
    localparam int unsigned ETH_MAX_BYTES = 1518;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic             ok;
        logic             crc_err;
        logic             len_err;
        logic             abort;
        logic [LEN_W-1:0] len;
    } rx_status_t;

    // One byte through the MSB-first register; byte bits enter LSB first (bit-reversed byte).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_rx_crc32_d16.sv
// CRC-32 register consuming one 16-bit word per cycle, high byte first.
module mac_rx_crc32_d16
    import mac_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_crc_reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic [31:0]       o_crc
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;

    always_comb begin
        w_crc_nxt = crc32_byte(crc32_byte(r_crc, i_data[15:8]), i_data[7:0]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_crc_reset) begin
            r_crc <= CRC32_INIT;
        end else if (i_valid) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/mac_rx_frame_check.sv
// Receive frame checker: CRC/length check, FCS strip via two-word delay line, per-frame status.
module mac_rx_frame_check
    import mac_pkg::*;
#(
    parameter int unsigned MIN_BYTES   = ETH_MIN_BYTES,
    parameter int unsigned MAX_BYTES   = ETH_MAX_BYTES,
    parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic              i_eof,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_status_valid,
    output logic              o_frame_ok,
    output logic              o_crc_err,
    output logic              o_len_err,
    output logic              o_abort,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_drop
);

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [BYTE_W-1:0] LEN_MAX = BYTE_W'(2047);

    rx_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [DATA_W-1:0] r_dly0, w_dly0_nxt;
    logic [DATA_W-1:0] r_dly1, w_dly1_nxt;
    logic              r_abort, w_abort_nxt;

    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_sof, w_sof_nxt;
    logic              r_eof, w_eof_nxt;
    logic              r_drop, w_drop_nxt;
    rx_status_t        r_status, w_status_nxt, w_status_calc;
    logic              r_status_valid, w_status_valid_nxt;

    logic              w_crc_en;
    logic              w_crc_clr;
    logic [31:0]       w_crc;
    logic [BYTE_W-1:0] w_bytes;
    logic [BYTE_W-1:0] w_len_raw;

    assign w_crc_clr = (r_state == ST_CHECK);

    mac_rx_crc32_d16 u_crc (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_crc_reset (w_crc_clr),
        .i_valid     (w_crc_en),
        .i_data      (i_data),
        .o_crc       (w_crc)
    );

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Status of the frame just finished; abort suppresses the CRC verdict.
    always_comb begin
        w_bytes   = BYTE_W'({r_cnt, 1'b0});
        w_len_raw = (r_cnt < CNT_W'(2)) ? '0 : BYTE_W'({r_cnt - CNT_W'(2), 1'b0});
        w_status_calc         = '0;
        w_status_calc.len     = (w_len_raw > LEN_MAX) ? LEN_W'(LEN_MAX) : w_len_raw[LEN_W-1:0];
        w_status_calc.len_err = (w_bytes < BYTE_W'(MIN_BYTES)) || (w_bytes > BYTE_W'(MAX_BYTES));
        w_status_calc.crc_err = !r_abort && (w_crc != CRC_RESIDUE);
        w_status_calc.abort   = r_abort;
        w_status_calc.ok      = !w_status_calc.crc_err && !w_status_calc.len_err && !r_abort;
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_dly0_nxt         = r_dly0;
        w_dly1_nxt         = r_dly1;
        w_abort_nxt        = r_abort;
        w_crc_en           = 1'b0;
        w_data_nxt         = r_data;
        w_valid_nxt        = 1'b0;
        w_sof_nxt          = 1'b0;
        w_eof_nxt          = 1'b0;
        w_drop_nxt         = 1'b0;
        w_status_nxt       = r_status;
        w_status_valid_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    if (i_sof) begin
                        w_crc_en    = 1'b1;
                        w_dly0_nxt  = i_data;
                        w_dly1_nxt  = '0;
                        w_cnt_nxt   = CNT_W'(1);
                        w_abort_nxt = 1'b0;
                        w_state_nxt = i_eof ? ST_CHECK : ST_RECV;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (i_valid) begin
                    if (i_sof) begin
                        w_drop_nxt  = 1'b1;
                        w_abort_nxt = 1'b1;
                        w_dly0_nxt  = '0;
                        w_dly1_nxt  = '0;
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_crc_en   = 1'b1;
                        w_dly1_nxt = r_dly0;
                        w_dly0_nxt = i_data;
                        w_cnt_nxt  = w_cnt_inc;
                        // Delay line full: the oldest word is payload, the two newest may be FCS.
                        if (r_cnt >= CNT_W'(2)) begin
                            w_data_nxt  = r_dly1;
                            w_valid_nxt = 1'b1;
                            w_sof_nxt   = (r_cnt == CNT_W'(2));
                            w_eof_nxt   = i_eof;
                        end
                        if (i_eof) begin
                            w_state_nxt = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                w_drop_nxt         = i_valid;
                w_status_nxt       = w_status_calc;
                w_status_valid_nxt = 1'b1;
                w_cnt_nxt          = '0;
                w_dly0_nxt         = '0;
                w_dly1_nxt         = '0;
                w_abort_nxt        = 1'b0;
                w_state_nxt        = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_dly0         <= '0;
            r_dly1         <= '0;
            r_abort        <= 1'b0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_sof          <= 1'b0;
            r_eof          <= 1'b0;
            r_drop         <= 1'b0;
            r_status       <= '0;
            r_status_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_dly0         <= w_dly0_nxt;
            r_dly1         <= w_dly1_nxt;
            r_abort        <= w_abort_nxt;
            r_data         <= w_data_nxt;
            r_valid        <= w_valid_nxt;
            r_sof          <= w_sof_nxt;
            r_eof          <= w_eof_nxt;
            r_drop         <= w_drop_nxt;
            r_status       <= w_status_nxt;
            r_status_valid <= w_status_valid_nxt;
        end
    end

    assign o_data         = r_data;
    assign o_valid        = r_valid;
    assign o_sof          = r_sof;
    assign o_eof          = r_eof;
    assign o_drop         = r_drop;
    assign o_status_valid = r_status_valid;
    assign o_frame_ok     = r_status.ok;
    assign o_crc_err      = r_status.crc_err;
    assign o_len_err      = r_status.len_err;
    assign o_abort        = r_status.abort;
    assign o_len          = r_status.len;

endmodule

// File: tb/tb_mac_rx_frame_check.sv
// Scoreboard bench for mac_rx_frame_check; FCS generated with an independent reflected CRC.
module tb_mac_rx_frame_check;
    import mac_pkg::*;

    typedef struct {
        bit ok;
        bit crc_err;
        bit len_err;
        bit abort;
        int len;
        bit chk_crc;
        bit chk_len;
    } exp_st_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_data;
    logic        i_valid;
    logic        i_sof;
    logic        i_eof;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_eof;
    logic        o_status_valid;
    logic        o_frame_ok;
    logic        o_crc_err;
    logic        o_len_err;
    logic        o_abort;
    logic [10:0] o_len;
    logic        o_drop;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int drop_cnt = 0;
    int eof_cyc = 0;
    int st_cyc  = 0;

    logic [17:0] exp_pay[$];
    logic [17:0] obs_pay[$];
    exp_st_t     exp_st[$];
    rx_status_t  obs_st[$];
    logic [15:0] fr_words[$];

    always #5 i_clk = ~i_clk;

    mac_rx_frame_check dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .i_sof          (i_sof),
        .i_eof          (i_eof),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_sof          (o_sof),
        .o_eof          (o_eof),
        .o_status_valid (o_status_valid),
        .o_frame_ok     (o_frame_ok),
        .o_crc_err      (o_crc_err),
        .o_len_err      (o_len_err),
        .o_abort        (o_abort),
        .o_len          (o_len),
        .o_drop         (o_drop)
    );

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output collector, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (o_valid === 1'b1) obs_pay.push_back({o_sof, o_eof, o_data});
        if (o_eof === 1'b1) eof_cyc <= cyc;
        if (o_status_valid === 1'b1) begin
            obs_st.push_back({o_frame_ok, o_crc_err, o_len_err, o_abort, o_len});
            st_cyc <= cyc;
        end
        if (o_drop === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    task automatic drive(input logic [15:0] d, input logic s, input logic e);
        i_data = d; i_valid = 1'b1; i_sof = s; i_eof = e;
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        i_data = '0; i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    // Payload bytes (i+seed), FCS from the LSB-first reflected CRC, appended low byte first.
    task automatic build_frame(input int npay, input int seed, input int flip_bit);
        logic [7:0]  bytes[$];
        logic [7:0]  b;
        logic [31:0] c;
        logic [15:0] w;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < npay; i++) begin
            b = 8'(i + seed);
            bytes.push_back(b);
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        bytes.push_back(c[7:0]);
        bytes.push_back(c[15:8]);
        bytes.push_back(c[23:16]);
        bytes.push_back(c[31:24]);
        fr_words.delete();
        for (int i = 0; i < bytes.size(); i += 2) fr_words.push_back({bytes[i], bytes[i+1]});
        if (flip_bit >= 0) begin
            w = fr_words[flip_bit / 16];
            w = w ^ (16'(1) << (flip_bit % 16));
            fr_words[flip_bit / 16] = w;
        end
    endtask

    task automatic send_frame(input bit bad_crc);
        int      n;
        exp_st_t e;
        n = fr_words.size();
        e.len     = (n < 2) ? 0 : 2 * (n - 2);
        e.len_err = (2 * n < 64) || (2 * n > 1518);
        e.crc_err = bad_crc;
        e.abort   = 1'b0;
        e.ok      = !bad_crc && !e.len_err;
        e.chk_crc = 1'b1;
        e.chk_len = 1'b1;
        exp_st.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (i < n - 2) exp_pay.push_back({1'(i == 0), 1'(i == n - 3), fr_words[i]});
            drive(fr_words[i], 1'(i == 0), 1'(i == n - 1));
        end
    endtask

    task automatic wait_status(input int want, output bit to);
        int k;
        k = 0;
        while (obs_st.size() < want && k < 3000) begin
            @(negedge i_clk);
            k++;
        end
        repeat (3) @(negedge i_clk);
        to = (obs_st.size() < want);
    endtask

    task automatic clear_sb();
        exp_pay.delete(); obs_pay.delete(); exp_st.delete(); obs_st.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle(3);
        n_tests++;
        if ({o_valid, o_sof, o_eof, o_data} !== 19'd0) begin
            n_fail++; $display("FAIL reset_datapath: got %h required 0", {o_valid, o_sof, o_eof, o_data});
        end
        n_tests++;
        if ({o_status_valid, o_frame_ok, o_crc_err, o_len_err, o_abort, o_len} !== 16'd0) begin
            n_fail++; $display("FAIL reset_status: got %h required 0",
                {o_status_valid, o_frame_ok, o_crc_err, o_len_err, o_abort, o_len});
        end
        n_tests++;
        if (o_drop !== 1'b0) begin
            n_fail++; $display("FAIL reset_drop: got %b required 0", o_drop);
        end
        i_rst = 1'b0;
        idle(2);
        clear_sb();
    endtask

    task automatic test_good_frame();
        bit to; logic [17:0] o, x; rx_status_t s; exp_st_t e;
        clear_sb();
        build_frame(60, 0, -1);
        send_frame(1'b0);
        idle(1);
        wait_status(1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL good_timeout: got %0d statuses required 1", obs_st.size()); end
        n_tests++;
        if (obs_pay.size() != 30) begin n_fail++; $display("FAIL good_pay_count: got %0d required 30", obs_pay.size()); end
        for (int i = 0; i < 30 && obs_pay.size() > 0; i++) begin
            o = obs_pay.pop_front(); x = exp_pay.pop_front();
            n_tests++;
            if (o[15:0] !== 16'((2 * i) * 256 + 2 * i + 1) || o !== x) begin
                n_fail++; $display("FAIL good_payload[%0d]: got %h required %h", i, o, x);
            end
        end
        n_tests++;
        if (st_cyc - eof_cyc != 1) begin n_fail++; $display("FAIL good_status_lag: got %0d required 1", st_cyc - eof_cyc); end
        if (obs_st.size() > 0) begin
            s = obs_st.pop_front(); e = exp_st.pop_front();
            n_tests++;
            if (s.ok !== 1'b1 || s.crc_err !== 1'b0 || s.len_err !== 1'b0 || s.abort !== 1'b0 || s.len !== 11'd60) begin
                n_fail++; $display("FAIL good_status: got ok=%b crc=%b len_err=%b abort=%b len=%0d required ok=%b len=%0d",
                    s.ok, s.crc_err, s.len_err, s.abort, s.len, e.ok, e.len);
            end
        end
    endtask

    // Runs one frame and checks payload stream and status against the scoreboard.
    task automatic test_frame(input string name, input int npay, input int seed, input int flip);
        bit to; logic [17:0] o, x; rx_status_t s; exp_st_t e;
        clear_sb();
        build_frame(npay, seed, flip);
        send_frame(flip >= 0);
        idle(1);
        wait_status(1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL %s_timeout: got %0d statuses required 1", name, obs_st.size()); end
        n_tests++;
        if (obs_pay.size() != exp_pay.size()) begin
            n_fail++; $display("FAIL %s_pay_count: got %0d required %0d", name, obs_pay.size(), exp_pay.size());
        end
        while (obs_pay.size() > 0 && exp_pay.size() > 0) begin
            o = obs_pay.pop_front(); x = exp_pay.pop_front();
            n_tests++;
            if (o !== x) begin n_fail++; $display("FAIL %s_payload: got %h required %h", name, o, x); end
        end
        if (obs_st.size() > 0) begin
            s = obs_st.pop_front(); e = exp_st.pop_front();
            n_tests++;
            if (s.ok !== e.ok || s.crc_err !== e.crc_err || s.len_err !== e.len_err || s.abort !== 1'b0 || s.len !== 11'(e.len)) begin
                n_fail++; $display("FAIL %s_status: got ok=%b crc=%b len_err=%b len=%0d required ok=%b crc=%b len_err=%b len=%0d",
                    name, s.ok, s.crc_err, s.len_err, s.len, e.ok, e.crc_err, e.len_err, e.len);
            end
        end
    endtask

    task automatic test_abort();
        bit to; logic [17:0] o, x; rx_status_t s; exp_st_t e; int d0;
        clear_sb();
        d0 = drop_cnt;
        build_frame(40, 16, -1);
        for (int i = 0; i < 9; i++) begin
            if (i < 7) exp_pay.push_back({1'(i == 0), 1'b0, fr_words[i]});
            drive(fr_words[i], 1'(i == 0), 1'b0);
        end
        e = '{ok: 1'b0, crc_err: 1'b0, len_err: 1'b0, abort: 1'b1, len: 0, chk_crc: 1'b1, chk_len: 1'b0};
        exp_st.push_back(e);
        drive(16'hBEEF, 1'b1, 1'b0);
        idle(1);
        build_frame(60, 128, -1);
        send_frame(1'b0);
        idle(1);
        wait_status(2, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL abort_timeout: got %0d statuses required 2", obs_st.size()); end
        n_tests++;
        if (drop_cnt - d0 != 1) begin n_fail++; $display("FAIL abort_drop: got %0d required 1", drop_cnt - d0); end
        n_tests++;
        if (obs_pay.size() != exp_pay.size()) begin
            n_fail++; $display("FAIL abort_pay_count: got %0d required %0d", obs_pay.size(), exp_pay.size());
        end
        while (obs_pay.size() > 0 && exp_pay.size() > 0) begin
            o = obs_pay.pop_front(); x = exp_pay.pop_front();
            n_tests++;
            if (o !== x) begin n_fail++; $display("FAIL abort_payload: got %h required %h", o, x); end
        end
        while (obs_st.size() > 0 && exp_st.size() > 0) begin
            s = obs_st.pop_front(); e = exp_st.pop_front();
            n_tests++;
            if (s.ok !== e.ok || s.abort !== e.abort || s.crc_err !== e.crc_err ||
                (e.chk_len && (s.len_err !== e.len_err || s.len !== 11'(e.len)))) begin
                n_fail++; $display("FAIL abort_status: got ok=%b crc=%b abort=%b len=%0d required ok=%b crc=%b abort=%b len=%0d",
                    s.ok, s.crc_err, s.abort, s.len, e.ok, e.crc_err, e.abort, e.len);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to; rx_status_t s; int d0; int n_ok;
        clear_sb();
        d0 = drop_cnt;
        build_frame(60, 32, -1);
        send_frame(1'b0);
        drive(16'h5555, 1'b0, 1'b0);
        build_frame(60, 48, -1);
        send_frame(1'b0);
        idle(1);
        wait_status(2, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL b2b_timeout: got %0d statuses required 2", obs_st.size()); end
        n_tests++;
        if (drop_cnt - d0 != 1) begin n_fail++; $display("FAIL b2b_drop: got %0d required 1", drop_cnt - d0); end
        n_tests++;
        if (obs_pay != exp_pay) begin
            n_fail++; $display("FAIL b2b_payload: got %0d words required %0d matching words", obs_pay.size(), exp_pay.size());
        end
        n_ok = 0;
        while (obs_st.size() > 0) begin
            s = obs_st.pop_front();
            if (s.ok === 1'b1 && s.len === 11'd60) n_ok++;
        end
        n_tests++;
        if (n_ok != 2) begin n_fail++; $display("FAIL b2b_status: got %0d ok frames required 2", n_ok); end
    endtask

    task automatic test_one_word();
        bit to; rx_status_t s; int d0;
        clear_sb();
        d0 = drop_cnt;
        drive(16'h1234, 1'b1, 1'b1);
        idle(1);
        drive(16'hAAAA, 1'b0, 1'b0);
        idle(1);
        wait_status(1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL one_word_timeout: got %0d statuses required 1", obs_st.size()); end
        n_tests++;
        if (obs_pay.size() != 0) begin n_fail++; $display("FAIL one_word_payload: got %0d words required 0", obs_pay.size()); end
        n_tests++;
        if (drop_cnt - d0 != 1) begin n_fail++; $display("FAIL idle_drop: got %0d required 1", drop_cnt - d0); end
        if (obs_st.size() > 0) begin
            s = obs_st.pop_front();
            n_tests++;
            if (s.ok !== 1'b0 || s.len_err !== 1'b1 || s.abort !== 1'b0 || s.len !== 11'd0) begin
                n_fail++; $display("FAIL one_word_status: got ok=%b len_err=%b abort=%b len=%0d required ok=0 len_err=1 abort=0 len=0",
                    s.ok, s.len_err, s.abort, s.len);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to; rx_status_t s;
        clear_sb();
        build_frame(60, 64, -1);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_pay.push_back({1'(i == 0), 1'b0, fr_words[i]});
            drive(fr_words[i], 1'(i == 0), 1'b0);
        end
        i_rst = 1'b1;
        idle(2);
        i_rst = 1'b0;
        n_tests++;
        if ({o_valid, o_status_valid, o_frame_ok, o_len, o_drop} !== 15'd0) begin
            n_fail++; $display("FAIL rst_mid_clear: got %h required 0", {o_valid, o_status_valid, o_frame_ok, o_len, o_drop});
        end
        idle(20);
        n_tests++;
        if (obs_st.size() != 0) begin n_fail++; $display("FAIL rst_mid_status: got %0d statuses required 0", obs_st.size()); end
        n_tests++;
        if (obs_pay != exp_pay) begin
            n_fail++; $display("FAIL rst_mid_payload: got %0d words required %0d matching words", obs_pay.size(), exp_pay.size());
        end
        clear_sb();
        build_frame(60, 3, -1);
        send_frame(1'b0);
        idle(1);
        wait_status(1, to);
        n_tests++;
        if (to) begin
            n_fail++; $display("FAIL rst_recover_timeout: got 0 statuses required 1");
        end else begin
            s = obs_st.pop_front();
            n_tests++;
            if (s.ok !== 1'b1 || s.len !== 11'd60) begin
                n_fail++; $display("FAIL rst_recover_status: got ok=%b len=%0d required ok=1 len=60", s.ok, s.len);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_data = '0; i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_good_frame();
        test_frame("crc_err", 60, 0, 5 * 16 + 3);
        test_frame("runt", 36, 7, -1);
        test_frame("oversize", 1516, 9, -1);
        test_abort();
        test_back_to_back();
        test_one_word();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
